// File: rtl/filtered_ram_bank_control.sv
// Double-buffered projection store for the filtered-data path.
// The host fills the load bank while two read ports serve the processing
// bank. Each granted next-angle request swaps the two banks and publishes
// the angle of the projection that has just been loaded.
module filtered_ram_bank_control #(
   parameter int ANGLE_W      = 9,
   parameter int DATA_W       = 12,
   parameter int S_W          = 10,
   parameter int PROJ_LEN     = 256,
   parameter int NO_OF_ANGLES = 180,
   parameter int ANGLE_STEP   = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      hs_start,
   input  logic signed [DATA_W-1:0]  hs_val,
   input  logic                      hs_val_valid,
   output logic                      hs_ready,
   output logic                      hs_done,
   output logic        [ANGLE_W-1:0] fr_angle,
   output logic                      fr_has_next_angle,
   input  logic                      fr_next_angle,
   output logic                      fr_next_angle_ack,
   input  logic signed [S_W-1:0]     fr0_s_val,
   input  logic signed [S_W-1:0]     fr1_s_val,
   output logic signed [DATA_W-1:0]  fr0_val,
   output logic signed [DATA_W-1:0]  fr1_val
);

   localparam int ADDR_W = (PROJ_LEN > 1) ? $clog2(PROJ_LEN) : 1;
   localparam int IDX_W  = $clog2(NO_OF_ANGLES + 1);

   localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(PROJ_LEN - 1);
   localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NO_OF_ANGLES - 1);
   // One extra bit so PROJ_LEN never aliases to a negative limit.
   localparam logic signed [S_W:0] RD_LIMIT  = (S_W + 1)'(PROJ_LEN);

   typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP, EXHAUSTED} state_t;

   state_t              state_q, state_d;
   logic                load_bank_q, load_bank_d;
   logic                proc_bank_q, proc_bank_d;
   logic [ADDR_W-1:0]   load_cnt_q, load_cnt_d;
   logic [IDX_W-1:0]    angle_idx_q, angle_idx_d;
   logic [ANGLE_W-1:0]  fr_angle_q, fr_angle_d;
   logic signed [DATA_W-1:0] fr0_val_q, fr1_val_q;
   logic                wr_en;
   logic                ack;

   logic signed [DATA_W-1:0] mem_q [0:1][0:PROJ_LEN-1];

   // Angle published for a projection: index times step, wrapped to ANGLE_W.
   function automatic logic [ANGLE_W-1:0] angle_of(input logic [IDX_W-1:0] idx);
      return ANGLE_W'(32'(idx) * 32'(ANGLE_STEP));
   endfunction

   // Reads outside 0..PROJ_LEN-1 (including negative addresses) return zero.
   function automatic logic in_range(input logic signed [S_W-1:0] s);
      logic signed [S_W:0] ext;
      ext = {s[S_W-1], s};
      return !s[S_W-1] && (ext < RD_LIMIT);
   endfunction

   // Next-state, bank swap and counter logic.
   always_comb begin
      state_d     = state_q;
      load_bank_d = load_bank_q;
      proc_bank_d = proc_bank_q;
      load_cnt_d  = load_cnt_q;
      angle_idx_d = angle_idx_q;
      fr_angle_d  = fr_angle_q;
      wr_en       = 1'b0;
      ack         = 1'b0;
      case (state_q)
         IDLE, EXHAUSTED: begin
            if (hs_start) begin
               state_d     = FILL;
               load_cnt_d  = '0;
               angle_idx_d = '0;
            end
         end
         FILL: begin
            if (hs_val_valid) begin
               wr_en = reset_n;
               if (load_cnt_q == LAST_ADDR) begin
                  load_cnt_d = '0;
                  state_d    = WAIT_SWAP;
               end else begin
                  load_cnt_d = load_cnt_q + ADDR_W'(1);
               end
            end
         end
         WAIT_SWAP: begin
            if (fr_next_angle) begin
               ack         = 1'b1;
               load_bank_d = proc_bank_q;
               proc_bank_d = load_bank_q;
               fr_angle_d  = angle_of(angle_idx_q);
               angle_idx_d = angle_idx_q + IDX_W'(1);
               state_d     = (angle_idx_q == LAST_IDX) ? EXHAUSTED : FILL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers; the processing bank starts opposite the load bank.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         load_bank_q <= 1'b0;
         proc_bank_q <= 1'b1;
         load_cnt_q  <= '0;
         angle_idx_q <= '0;
         fr_angle_q  <= '0;
      end else begin
         state_q     <= state_d;
         load_bank_q <= load_bank_d;
         proc_bank_q <= proc_bank_d;
         load_cnt_q  <= load_cnt_d;
         angle_idx_q <= angle_idx_d;
         fr_angle_q  <= fr_angle_d;
      end
   end

   // Host write port into the load bank; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[load_bank_q][load_cnt_q] <= hs_val;
      end
   end

   // Two registered read ports on the processing bank.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fr0_val_q <= '0;
         fr1_val_q <= '0;
      end else begin
         fr0_val_q <= in_range(fr0_s_val) ? mem_q[proc_bank_q][fr0_s_val[ADDR_W-1:0]] : '0;
         fr1_val_q <= in_range(fr1_s_val) ? mem_q[proc_bank_q][fr1_s_val[ADDR_W-1:0]] : '0;
      end
   end

   assign hs_ready          = (state_q == FILL);
   assign hs_done           = (state_q == EXHAUSTED);
   assign fr_has_next_angle = (state_q == FILL) || (state_q == WAIT_SWAP);
   assign fr_next_angle_ack = ack;
   assign fr_angle          = fr_angle_q;
   assign fr0_val           = fr0_val_q;
   assign fr1_val           = fr1_val_q;

endmodule

// File: tb/tb_filtered_ram_bank_control.sv
// Scoreboard bench for filtered_ram_bank_control with an 8-sample,
// 3-angle, 60-degree-step configuration.
module tb_filtered_ram_bank_control;

   localparam int ANGLE_W = 9;
   localparam int DATA_W  = 12;
   localparam int S_W     = 10;
   localparam int PL      = 8;
   localparam int NA      = 3;
   localparam int STEP    = 60;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     hs_start;
   logic signed [DATA_W-1:0] hs_val;
   logic                     hs_val_valid;
   logic                     hs_ready;
   logic                     hs_done;
   logic [ANGLE_W-1:0]       fr_angle;
   logic                     fr_has_next_angle;
   logic                     fr_next_angle;
   logic                     fr_next_angle_ack;
   logic signed [S_W-1:0]    fr0_s_val;
   logic signed [S_W-1:0]    fr1_s_val;
   logic signed [DATA_W-1:0] fr0_val;
   logic signed [DATA_W-1:0] fr1_val;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: two banks plus which one is loading / processing.
   int bank_m [2][PL];
   int load_m = 0;
   int proc_m = 1;
   int q0[$];
   int q1[$];

   filtered_ram_bank_control #(
      .ANGLE_W(ANGLE_W), .DATA_W(DATA_W), .S_W(S_W),
      .PROJ_LEN(PL), .NO_OF_ANGLES(NA), .ANGLE_STEP(STEP)
   ) dut (
      .clk(clk), .reset_n(reset_n), .hs_start(hs_start),
      .hs_val(hs_val), .hs_val_valid(hs_val_valid), .hs_ready(hs_ready),
      .hs_done(hs_done), .fr_angle(fr_angle),
      .fr_has_next_angle(fr_has_next_angle), .fr_next_angle(fr_next_angle),
      .fr_next_angle_ack(fr_next_angle_ack),
      .fr0_s_val(fr0_s_val), .fr1_s_val(fr1_s_val),
      .fr0_val(fr0_val), .fr1_val(fr1_val)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model_rd(input int a);
      if (a < 0 || a >= PL) return 0;
      return bank_m[proc_m][a];
   endfunction

   // Advance one clock and retire any reads issued in the previous cycle.
   task automatic step();
      @(posedge clk);
      #1;
      while (q0.size() > 0) chk("fr0_val", fr0_val, q0.pop_front());
      while (q1.size() > 0) chk("fr1_val", fr1_val, q1.pop_front());
   endtask

   task automatic rd(input int a0, input int a1);
      fr0_s_val = S_W'(a0);
      fr1_s_val = S_W'(a1);
      q0.push_back(model_rd(a0));
      q1.push_back(model_rd(a1));
   endtask

   task automatic swap_model();
      int t;
      t = load_m;
      load_m = proc_m;
      proc_m = t;
   endtask

   // Write n samples base..base+n-1; optional bubble cycle, optional
   // request raised on the last write, optional reads alongside.
   task automatic fill(input int base, input int n, input int bubble_at,
                       input bit req_last, input bit with_reads);
      int k;
      k = 0;
      for (int c = 0; k < n; c++) begin
         if (c == bubble_at) begin
            hs_val_valid = 1'b0;
         end else begin
            hs_val_valid = 1'b1;
            hs_val = DATA_W'(base + k);
            if (req_last && k == n - 1) fr_next_angle = 1'b1;
         end
         if (with_reads) rd(k, PL - 1 - k);
         #1;
         chk("hs_ready_fill", hs_ready, 1);
         chk("ack_in_fill", fr_next_angle_ack, 0);
         step();
         if (c != bubble_at) begin
            bank_m[load_m][k] = base + k;
            k++;
         end
      end
      hs_val_valid = 1'b0;
   endtask

   // Grant cycle: request high in WAIT_SWAP, expect one ack then the angle.
   task automatic grant(input int exp_angle);
      fr_next_angle = 1'b1;
      #1;
      chk("ack_grant", fr_next_angle_ack, 1);
      chk("hs_ready_wait", hs_ready, 0);
      step();
      swap_model();
      fr_next_angle = 1'b0;
      #1;
      chk("ack_after", fr_next_angle_ack, 0);
      chk("fr_angle", fr_angle, exp_angle);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; hs_start = 1'b0; hs_val = '0; hs_val_valid = 1'b0;
      fr_next_angle = 1'b0; fr0_s_val = '0; fr1_s_val = '0;
      repeat (3) step();
      reset_n = 1'b1;
      step();
      chk("rst_hs_ready", hs_ready, 0);
      chk("rst_has_next", fr_has_next_angle, 0);
      chk("rst_hs_done", hs_done, 0);
      chk("rst_fr0", fr0_val, 0);
      chk("rst_fr1", fr1_val, 0);
      chk("rst_angle", fr_angle, 0);

      // Idle: valid samples without start are ignored.
      hs_val_valid = 1'b1; hs_val = 12'sd55;
      repeat (3) begin
         #1;
         chk("idle_ready", hs_ready, 0);
         step();
      end
      hs_val_valid = 1'b0;
      chk("idle_has_next", fr_has_next_angle, 0);

      // Angle 0: request held throughout, bubble after the 4th sample.
      fr_next_angle = 1'b1;
      hs_start = 1'b1;
      step();
      hs_start = 1'b0;
      chk("fill_has_next", fr_has_next_angle, 1);
      fill(1, PL, 4, 1'b0, 1'b0);
      chk("wait_has_next", fr_has_next_angle, 1);
      grant(0);
      rd(3, 7);  step();
      rd(-1, 8); step();
      rd(8, -1); step();
      rd(0, 0);  step();
      rd(511, -512); step();

      // Angle 60: reads keep seeing the processing bank while filling.
      fill(101, PL, -1, 1'b0, 1'b1);
      rd(0, 1);                 // issued in the ack cycle: old bank
      grant(60);
      rd(0, 7); step();

      // Angle 120: request raised together with the last write.
      fill(201, PL, -1, 1'b1, 1'b0);
      grant(120);
      chk("exh_has_next", fr_has_next_angle, 0);
      chk("exh_hs_done", hs_done, 1);
      chk("exh_hs_ready", hs_ready, 0);
      fr_next_angle = 1'b1; hs_val_valid = 1'b1; hs_val = 12'sd77;
      repeat (2) begin
         #1;
         chk("exh_no_ack", fr_next_angle_ack, 0);
         rd(0, 7);
         step();
      end
      fr_next_angle = 1'b0; hs_val_valid = 1'b0;

      // New frame, then start mid-fill (ignored) and reset after 5 samples.
      hs_start = 1'b1;
      step();
      hs_start = 1'b0;
      chk("restart_done", hs_done, 0);
      chk("restart_ready", hs_ready, 1);
      chk("restart_has_next", fr_has_next_angle, 1);
      for (int k = 0; k < 5; k++) begin
         hs_val_valid = 1'b1;
         hs_val = DATA_W'(301 + k);
         hs_start = (k == 2);
         step();
         bank_m[load_m][k] = 301 + k;
      end
      hs_val_valid = 1'b0; hs_start = 1'b0;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      load_m = 0; proc_m = 1;
      chk("mid_rst_ready", hs_ready, 0);
      chk("mid_rst_has_next", fr_has_next_angle, 0);
      chk("mid_rst_done", hs_done, 0);
      chk("mid_rst_angle", fr_angle, 0);
      chk("mid_rst_fr0", fr0_val, 0);
      chk("mid_rst_fr1", fr1_val, 0);
      rd(0, 7); step();
      rd(2, 4); step();

      // Fresh frame after reset.
      fr_next_angle = 1'b1;
      hs_start = 1'b1;
      step();
      hs_start = 1'b0;
      fill(401, PL, -1, 1'b0, 1'b0);
      grant(0);
      rd(0, 7); step();
      rd(5, 5); step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
